// File: rtl/fifo_pkg.sv
// Shared definitions for the byte fifo and its host controller:
// host FSM encoding, arbitration grant type and fifo_status bit positions.
package fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_READ   = 2'd2,
        ST_SETTLE = 2'd3
    } host_state_e;

    typedef enum logic {
        GRANT_WRITE = 1'b0,
        GRANT_READ  = 1'b1
    } grant_e;

    localparam int unsigned STATUS_WIDTH    = 8;
    localparam int unsigned FS_EMPTY        = 0;
    localparam int unsigned FS_FULL         = 1;
    localparam int unsigned FS_UNDERFLOW    = 2;
    localparam int unsigned FS_OVERFLOW     = 3;
    localparam int unsigned FS_ALMOST_EMPTY = 4;
    localparam int unsigned FS_ALMOST_FULL  = 5;

    function automatic grant_e other_grant(input grant_e g);
        return (g == GRANT_WRITE) ? GRANT_READ : GRANT_WRITE;
    endfunction

endpackage

// File: rtl/fifo_host_if.sv
// Byte-stream and fifo-pin bundle between fifo_host (slave) and its surroundings (master).
interface fifo_host_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] fifo_din;
    logic       fifo_wr;
    logic       fifo_rd;
    logic [7:0] fifo_dout;
    logic [7:0] fifo_status;

    modport slave (
        input  s_data, s_valid, m_ready, fifo_dout, fifo_status,
        output s_ready, m_data, m_valid, fifo_din, fifo_wr, fifo_rd
    );

    modport master (
        output s_data, s_valid, m_ready, fifo_dout, fifo_status,
        input  s_ready, m_data, m_valid, fifo_din, fifo_wr, fifo_rd
    );
endinterface

// File: rtl/fifo.sv
// Team byte fifo: first-word-fall-through with registered read; data and status
// flags reflect a write or read two clock edges after the request.
module fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr,
    input  logic                    rd,
    input  logic [7:0]              din,
    output logic [7:0]              dout,
    output logic [STATUS_WIDTH-1:0] status
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]              mem [DEPTH];
    logic [7:0]              dout_q;
    logic [AW-1:0]           wp_q, wp_d;
    logic [AW-1:0]           rp_q, rp_d;
    logic [CW-1:0]           count_q, count_d;
    logic [STATUS_WIDTH-1:0] status_q, status_d;
    logic                    is_full, is_empty, wr_ok, rd_ok;

    always_comb begin
        is_full  = (count_q == CW'(DEPTH));
        is_empty = (count_q == '0);
        wr_ok    = wr && !is_full;
        rd_ok    = rd && !is_empty;
        wp_d     = wr_ok ? wp_q + 1'b1 : wp_q;
        rp_d     = rd_ok ? rp_q + 1'b1 : rp_q;
        count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);

        // Flags follow the count one edge late so they line up with dout_q.
        status_d                  = '0;
        status_d[FS_EMPTY]        = is_empty;
        status_d[FS_FULL]         = is_full;
        status_d[FS_UNDERFLOW]    = rd && is_empty;
        status_d[FS_OVERFLOW]     = wr && is_full;
        status_d[FS_ALMOST_EMPTY] = (count_q <= CW'(1));
        status_d[FS_ALMOST_FULL]  = (count_q >= CW'(DEPTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q     <= '0;
            rp_q     <= '0;
            count_q  <= '0;
            status_q <= STATUS_WIDTH'((1 << FS_EMPTY) | (1 << FS_ALMOST_EMPTY));
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            count_q  <= count_d;
            status_q <= status_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wp_q] <= din;
        end
        dout_q <= mem[rp_q];
    end

    assign dout   = dout_q;
    assign status = status_q;

endmodule

// File: rtl/fifo_host.sv
// Host controller for a pin-level fifo: one-byte input register, round-robin
// write/read arbitration, settle gaps between pulses, and a one-byte output stage.
module fifo_host
    import fifo_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fifo_host_if.slave           bus,
    output logic                 err_overflow,
    output logic                 err_underflow,
    output logic [CNT_WIDTH-1:0] wr_count,
    output logic [CNT_WIDTH-1:0] rd_count
);

    localparam int unsigned SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam host_state_e AFTER_OP = (SETTLE_CYCLES == 0) ? ST_IDLE : ST_SETTLE;

    host_state_e          state_q, state_d;
    logic [SC_W-1:0]      settle_cnt_q, settle_cnt_d;
    logic [7:0]           in_data_q, in_data_d;
    logic                 in_full_q, in_full_d;
    grant_e               prio_q, prio_d;
    logic                 fifo_wr_q, fifo_wr_d;
    logic                 fifo_rd_q, fifo_rd_d;
    logic [7:0]           fifo_din_q, fifo_din_d;
    logic [7:0]           m_data_q, m_data_d;
    logic                 m_valid_q, m_valid_d;
    logic                 err_ovf_q, err_ovf_d;
    logic                 err_unf_q, err_unf_d;
    logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;

    logic write_want, read_want, grant_w, grant_r, settle_last;
    logic unused_status_bits;

    assign unused_status_bits = ^{bus.fifo_status[7:6], bus.fifo_status[FS_ALMOST_FULL],
                                  bus.fifo_status[FS_ALMOST_EMPTY]};

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        in_data_d    = in_data_q;
        in_full_d    = in_full_q;
        prio_d       = prio_q;
        fifo_wr_d    = 1'b0;
        fifo_rd_d    = 1'b0;
        fifo_din_d   = fifo_din_q;
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        err_ovf_d    = err_ovf_q | bus.fifo_status[FS_OVERFLOW];
        err_unf_d    = err_unf_q | bus.fifo_status[FS_UNDERFLOW];

        write_want  = in_full_q && !bus.fifo_status[FS_FULL];
        read_want   = !bus.fifo_status[FS_EMPTY] && !m_valid_q;
        grant_w     = write_want && (!read_want || prio_q == GRANT_WRITE);
        grant_r     = read_want && !grant_w;
        settle_last = (settle_cnt_q == SC_W'(SETTLE_CYCLES - 1));

        if (m_valid_q && bus.m_ready) begin
            m_valid_d = 1'b0;
        end

        if (bus.s_valid && !in_full_q) begin
            in_data_d = bus.s_data;
            in_full_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (grant_w) begin
                    // The byte moves to fifo_din_q here, so the register is free during WRITE.
                    state_d    = ST_WRITE;
                    fifo_wr_d  = 1'b1;
                    fifo_din_d = in_data_q;
                    in_full_d  = 1'b0;
                    prio_d     = other_grant(GRANT_WRITE);
                end else if (grant_r) begin
                    state_d   = ST_READ;
                    fifo_rd_d = 1'b1;
                    m_data_d  = bus.fifo_dout;
                    m_valid_d = 1'b1;
                    prio_d    = other_grant(GRANT_READ);
                end
            end
            ST_WRITE: begin
                wr_cnt_d     = wr_cnt_q + 1'b1;
                settle_cnt_d = '0;
                state_d      = AFTER_OP;
            end
            ST_READ: begin
                rd_cnt_d     = rd_cnt_q + 1'b1;
                settle_cnt_d = '0;
                state_d      = AFTER_OP;
            end
            ST_SETTLE: begin
                if (settle_last) begin
                    state_d = ST_IDLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            in_data_q    <= '0;
            in_full_q    <= 1'b0;
            prio_q       <= GRANT_WRITE;
            fifo_wr_q    <= 1'b0;
            fifo_rd_q    <= 1'b0;
            fifo_din_q   <= '0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_unf_q    <= 1'b0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            in_data_q    <= in_data_d;
            in_full_q    <= in_full_d;
            prio_q       <= prio_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_rd_q    <= fifo_rd_d;
            fifo_din_q   <= fifo_din_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            err_ovf_q    <= err_ovf_d;
            err_unf_q    <= err_unf_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
        end
    end

    assign bus.s_ready    = !in_full_q;
    assign bus.m_data     = m_data_q;
    assign bus.m_valid    = m_valid_q;
    assign bus.fifo_din   = fifo_din_q;
    assign bus.fifo_wr    = fifo_wr_q;
    assign bus.fifo_rd    = fifo_rd_q;
    assign err_overflow   = err_ovf_q;
    assign err_underflow  = err_unf_q;
    assign wr_count       = wr_cnt_q;
    assign rd_count       = rd_cnt_q;

endmodule

// File: tb/tb_fifo_host.sv
// Bench for fifo_host driving the team fifo (depth 32): queue-based scoreboard
// checked every cycle, plus directed scenarios with hand-computed results.
module tb_fifo_host;
    import fifo_pkg::*;

    localparam int SETTLE = 2;
    localparam int CW     = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_host_if bus ();
    logic          err_overflow, err_underflow;
    logic [CW-1:0] wr_count, rd_count;
    logic [7:0]    fifo_status_raw;
    logic [7:0]    fifo_dout_w;
    logic [7:0]    force_mask;

    fifo_host #(.SETTLE_CYCLES(SETTLE), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .err_overflow(err_overflow), .err_underflow(err_underflow),
        .wr_count(wr_count), .rd_count(rd_count)
    );

    fifo #(.DEPTH(32)) u_fifo (
        .clk(clk), .rst_n(rst_n), .wr(bus.fifo_wr), .rd(bus.fifo_rd),
        .din(bus.fifo_din), .dout(fifo_dout_w), .status(fifo_status_raw)
    );

    assign bus.fifo_dout   = fifo_dout_w;
    assign bus.fifo_status = fifo_status_raw | force_mask;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard state: bytes accepted upstream flow to fifo_din and then to m_data in order.
    logic [7:0] wr_q[$];
    logic [7:0] dlv_q[$];
    logic [7:0] log_q[$];
    int         model_wr = 0, model_rd = 0;
    bit         ovf_seen = 0, unf_seen = 0;
    int         idle_run = 0;
    bit         have_pulse = 0;
    bit         prev_mv = 0, prev_mr = 0;
    logic [7:0] prev_md = '0;
    int         cyc = 0;
    bit         rec_en = 0;
    int         pulse_cyc[$];
    bit         pulse_isw[$];

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            wr_q.delete();
            dlv_q.delete();
            model_wr   = 0;
            model_rd   = 0;
            ovf_seen   = 0;
            unf_seen   = 0;
            idle_run   = 0;
            have_pulse = 0;
            prev_mv    = 0;
            prev_mr    = 0;
            prev_md    = '0;
        end else begin
            check("wr_rd_exclusive", 32'(bus.fifo_wr && bus.fifo_rd), 32'd0);
            check("wr_count_model", 32'(wr_count), model_wr & 32'hFFFF);
            check("rd_count_model", 32'(rd_count), model_rd & 32'hFFFF);
            check("err_overflow_model", 32'(err_overflow), 32'(ovf_seen));
            check("err_underflow_model", 32'(err_underflow), 32'(unf_seen));

            if (prev_mv && !prev_mr) begin
                check("m_valid_hold", 32'(bus.m_valid), 32'd1);
                check("m_data_hold", 32'(bus.m_data), 32'(prev_md));
            end else if (prev_mv && prev_mr && !bus.fifo_rd) begin
                check("m_valid_clear", 32'(bus.m_valid), 32'd0);
            end

            if (bus.fifo_wr || bus.fifo_rd) begin
                if (have_pulse) check("settle_gap_ok", 32'(idle_run >= SETTLE), 32'd1);
                have_pulse = 1;
                idle_run   = 0;
                if (rec_en) begin
                    pulse_cyc.push_back(cyc);
                    pulse_isw.push_back(bus.fifo_wr);
                end
            end else begin
                idle_run++;
            end

            if (bus.fifo_wr) begin
                if (wr_q.size() == 0) check("write_has_byte", 32'd0, 32'd1);
                else check("fifo_din_order", 32'(bus.fifo_din), 32'(wr_q.pop_front()));
                model_wr++;
            end
            if (bus.fifo_rd) begin
                check("m_valid_on_read", 32'(bus.m_valid), 32'd1);
                model_rd++;
            end

            if (bus.m_valid && bus.m_ready) begin
                if (dlv_q.size() == 0) check("delivery_expected", 32'd0, 32'd1);
                else check("m_data_order", 32'(bus.m_data), 32'(dlv_q.pop_front()));
                log_q.push_back(bus.m_data);
                $display("m xfer %0d data=0x%02h wr_count=%0d rd_count=%0d",
                         log_q.size(), bus.m_data, wr_count, rd_count);
            end
            if (bus.s_valid && bus.s_ready) begin
                wr_q.push_back(bus.s_data);
                dlv_q.push_back(bus.s_data);
            end

            ovf_seen = ovf_seen | bus.fifo_status[FS_OVERFLOW];
            unf_seen = unf_seen | bus.fifo_status[FS_UNDERFLOW];
            prev_mv  = bus.m_valid;
            prev_mr  = bus.m_ready;
            prev_md  = bus.m_data;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers n consecutive bytes; gives up on a byte after stall_limit cycles without acceptance.
    task automatic send(input int n, input logic [7:0] first, input int stall_limit, output int sent);
        int  waited;
        bit  done;
        sent = 0;
        for (int i = 0; i < n; i++) begin
            waited      = 0;
            done        = 0;
            bus.s_valid = 1'b1;
            bus.s_data  = first + 8'(i);
            while (!done && waited < stall_limit) begin
                @(negedge clk);
                done = bus.s_ready;
                @(posedge clk);
                #1;
                waited++;
            end
            if (!done) break;
            sent++;
        end
        bus.s_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  sent;
        bit  found;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.m_ready = 1'b0;
        force_mask  = 8'h00;

        // Reset values
        step(3);
        check("rst_fifo_wr", 32'(bus.fifo_wr), 32'd0);
        check("rst_fifo_rd", 32'(bus.fifo_rd), 32'd0);
        check("rst_fifo_din", 32'(bus.fifo_din), 32'd0);
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_m_data", 32'(bus.m_data), 32'd0);
        check("rst_err_overflow", 32'(err_overflow), 32'd0);
        check("rst_err_underflow", 32'(err_underflow), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check("rst_rd_count", 32'(rd_count), 32'd0);
        rst_n = 1'b1;
        step(1);
        check("rst_s_ready", 32'(bus.s_ready), 32'd1);

        // Short stream, downstream always ready
        bus.m_ready = 1'b1;
        log_q.delete();
        send(5, 8'h01, 50, sent);
        check("p1_sent", 32'(sent), 32'd5);
        step(100);
        check("p1_wr_count", 32'(wr_count), 32'd5);
        check("p1_rd_count", 32'(rd_count), 32'd5);
        check("p1_delivered", 32'(log_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < log_q.size(); i++)
            check("p1_data", 32'(log_q[i]), 32'(i + 1));
        check("p1_m_valid_idle", 32'(bus.m_valid), 32'd0);

        // Fill: 1 byte held in m, 32 in the fifo, 1 in the input register
        bus.m_ready = 1'b0;
        log_q.delete();
        send(40, 8'h10, 60, sent);
        check("p2_accepted", 32'(sent), 32'd34);
        check("p2_s_ready", 32'(bus.s_ready), 32'd0);
        check("p2_fifo_full", 32'(bus.fifo_status[FS_FULL]), 32'd1);
        check("p2_wr_count", 32'(wr_count), 32'd38);
        check("p2_rd_count", 32'(rd_count), 32'd6);
        check("p2_m_data", 32'(bus.m_data), 32'h10);
        check("p2_err_overflow", 32'(err_overflow), 32'd0);

        // Drain everything
        bus.m_ready = 1'b1;
        step(300);
        check("p3_delivered", 32'(log_q.size()), 32'd34);
        for (int i = 0; i < 34 && i < log_q.size(); i++)
            check("p3_data", 32'(log_q[i]), 32'(8'h10 + i));
        check("p3_fifo_empty", 32'(bus.fifo_status[FS_EMPTY]), 32'd1);
        check("p3_err_underflow", 32'(err_underflow), 32'd0);
        check("p3_wr_count", 32'(wr_count), 32'd39);
        check("p3_rd_count", 32'(rd_count), 32'd39);

        // Sticky overflow flag from a one-cycle status pulse
        step(1);
        force_mask = 8'h08;
        step(1);
        force_mask = 8'h00;
        step(3);
        check("p4_err_overflow_set", 32'(err_overflow), 32'd1);
        step(10);
        check("p4_err_overflow_sticky", 32'(err_overflow), 32'd1);
        check("p4_err_underflow", 32'(err_underflow), 32'd0);
        rst_n = 1'b0;
        #1;
        check("p4_err_overflow_rst", 32'(err_overflow), 32'd0);
        step(1);
        rst_n = 1'b1;
        step(2);
        check("p4_err_overflow_after", 32'(err_overflow), 32'd0);

        // Reset in the middle of a READ pulse
        bus.m_ready = 1'b0;
        send(1, 8'hA5, 20, sent);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #1;
            if (bus.fifo_rd) found = 1;
        end
        check("p5_read_seen", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("p5_fifo_rd", 32'(bus.fifo_rd), 32'd0);
        check("p5_fifo_wr", 32'(bus.fifo_wr), 32'd0);
        check("p5_fifo_din", 32'(bus.fifo_din), 32'd0);
        check("p5_m_valid", 32'(bus.m_valid), 32'd0);
        check("p5_m_data", 32'(bus.m_data), 32'd0);
        check("p5_wr_count", 32'(wr_count), 32'd0);
        check("p5_rd_count", 32'(rd_count), 32'd0);
        check("p5_err_overflow", 32'(err_overflow), 32'd0);
        check("p5_err_underflow", 32'(err_underflow), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(1);
        check("p5_s_ready", 32'(bus.s_ready), 32'd1);
        check("p5_m_valid_after", 32'(bus.m_valid), 32'd0);

        // Continuous traffic: grants alternate starting with READ (last grant was WRITE)
        send(3, 8'h40, 40, sent);
        step(20);
        pulse_cyc.delete();
        pulse_isw.delete();
        log_q.delete();
        rec_en      = 1;
        bus.m_ready = 1'b1;
        send(12, 8'h50, 20, sent);
        rec_en = 0;
        check("p6_sent", 32'(sent), 32'd12);
        check("p6_pulse_count_ok", 32'(pulse_isw.size() >= 16), 32'd1);
        if (pulse_isw.size() > 0) check("p6_first_is_read", 32'(pulse_isw[0]), 32'd0);
        for (int k = 1; k < pulse_isw.size(); k++) begin
            check("p6_alternate", 32'(pulse_isw[k] != pulse_isw[k-1]), 32'd1);
            check("p6_gap_range", 32'((pulse_cyc[k] - pulse_cyc[k-1] - 1) >= SETTLE &&
                                      (pulse_cyc[k] - pulse_cyc[k-1] - 1) <= SETTLE + 1), 32'd1);
        end
        step(200);
        check("p6_all_delivered", 32'(dlv_q.size()), 32'd0);
        check("p6_wr_count", 32'(wr_count), 32'd15);
        check("p6_rd_count", 32'(rd_count), 32'd15);
        check("p6_last_byte", 32'(log_q.size() > 0 ? log_q[log_q.size()-1] : 8'h00), 32'h5B);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
